// File: rtl/wb_cnn_slave.sv
// wb_cnn_slave: Wishbone B3 classic slave bridging register accesses to CNN pixel/result FIFOs.
// Optional WB_CNN_ERR_EN: overflow/underflow accesses terminate with err instead of ack.
`default_nettype none

module wb_cnn_slave #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o,
  output logic          cnn_start_o,
  input  logic          cnn_done_i,
  output logic [DW-1:0] in_data_o,
  output logic          in_valid_o,
  input  logic          in_ready_i,
  input  logic [DW-1:0] out_data_i,
  input  logic          out_valid_i,
  output logic          out_ready_o,
  output logic          irq_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state, state_nx;

  logic          access, wr, rd;
  logic [1:0]    reg_sel;
  logic          busy, done, irq_en, wr_ovf, rd_udf, rdy_en;
  logic          start_q, ack_q, err_q;
  logic [31:0]   dat_q, rdata;

  logic [DW-1:0] in_mem  [DEPTH];
  logic [DW-1:0] out_mem [DEPTH];
  logic [AW:0]   in_wp, in_rp, out_wp, out_rp;
  logic          in_empty, in_full, out_empty, out_full;
  logic          bus_push, core_pop, core_push, bus_pop;
  logic          ovf, udf, clear, start, bad_access;
  logic [7:0]    in_lvl, out_lvl;

  // Sideband inputs are accepted but carry no meaning for full-word classic cycles.
  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  function automatic logic [7:0] sat8(input logic [AW:0] lvl);
    logic [31:0] w;
    w = 32'(lvl);
    sat8 = (w > 32'd255) ? 8'hFF : w[7:0];
  endfunction

  assign access  = (state == IDLE) && wb_cyc_i && wb_stb_i;
  assign wr      = access && wb_we_i;
  assign rd      = access && !wb_we_i;
  assign reg_sel = wb_adr_i[3:2];

  assign in_empty  = (in_wp == in_rp);
  assign in_full   = (in_wp[AW] != in_rp[AW]) && (in_wp[AW-1:0] == in_rp[AW-1:0]);
  assign out_empty = (out_wp == out_rp);
  assign out_full  = (out_wp[AW] != out_rp[AW]) && (out_wp[AW-1:0] == out_rp[AW-1:0]);

  assign bus_push  = wr && (reg_sel == 2'd2) && !in_full;
  assign ovf       = wr && (reg_sel == 2'd2) && in_full;
  assign core_pop  = !in_empty && in_ready_i;
  assign core_push = out_valid_i && out_ready_o;
  assign bus_pop   = rd && (reg_sel == 2'd3) && !out_empty;
  assign udf       = rd && (reg_sel == 2'd3) && out_empty;
  assign clear     = wr && (reg_sel == 2'd0) && wb_dat_i[1];
  assign start     = wr && (reg_sel == 2'd0) && wb_dat_i[0] && !busy;
  assign bad_access = ovf || udf;

  assign in_lvl  = sat8(in_wp - in_rp);
  assign out_lvl = sat8(out_wp - out_rp);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = {29'b0, irq_en, 1'b0, busy};
      2'd1: rdata = {in_lvl, out_lvl, 12'b0, rd_udf, wr_ovf, 1'b0, done};
      2'd2: rdata = '0;
      2'd3: rdata = out_empty ? 32'd0 : 32'(out_mem[out_rp[AW-1:0]]);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state   <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      start_q <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      state   <= state_nx;
`ifdef WB_CNN_ERR_EN
      ack_q   <= access && !bad_access;
      err_q   <= access && bad_access;
`else
      ack_q   <= access;
      err_q   <= 1'b0;
`endif
      dat_q   <= rd ? rdata : 32'd0;
      start_q <= start;
      rdy_en  <= 1'b1;
    end
  end

  // Core-side events win the sticky race: done set and W1C on the same edge keeps done.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      irq_en <= 1'b0;
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else begin
      if (start)           busy <= 1'b1;
      else if (cnn_done_i) busy <= 1'b0;

      if (cnn_done_i)                                    done <= 1'b1;
      else if (wr && (reg_sel == 2'd1) && wb_dat_i[0])   done <= 1'b0;

      if (ovf)                                           wr_ovf <= 1'b1;
      else if (wr && (reg_sel == 2'd1) && wb_dat_i[2])   wr_ovf <= 1'b0;

      if (udf)                                           rd_udf <= 1'b1;
      else if (wr && (reg_sel == 2'd1) && wb_dat_i[3])   rd_udf <= 1'b0;

      if (wr && (reg_sel == 2'd0)) irq_en <= wb_dat_i[2];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      in_wp  <= '0;
      in_rp  <= '0;
      out_wp <= '0;
      out_rp <= '0;
    end else if (clear) begin
      in_wp  <= '0;
      in_rp  <= '0;
      out_wp <= '0;
      out_rp <= '0;
    end else begin
      if (bus_push)  in_wp  <= in_wp + 1'b1;
      if (core_pop)  in_rp  <= in_rp + 1'b1;
      if (core_push) out_wp <= out_wp + 1'b1;
      if (bus_pop)   out_rp <= out_rp + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (bus_push)  in_mem[in_wp[AW-1:0]]   <= wb_dat_i[DW-1:0];
    if (core_push) out_mem[out_wp[AW-1:0]] <= out_data_i;
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_rty_o    = 1'b0;
  assign cnn_start_o = start_q;
  assign irq_o       = done && irq_en;
  assign in_valid_o  = !in_empty;
  assign in_data_o   = in_empty ? '0 : in_mem[in_rp[AW-1:0]];
  // Held low until the first clock after reset so every output reads 0 in reset.
  assign out_ready_o = rdy_en && !out_full;

endmodule

`default_nettype wire

// File: tb/tb_wb_cnn_slave.sv
// tb_wb_cnn_slave: directed Wishbone register/stream vectors for wb_cnn_slave.
// Expected err/ack on overflow/underflow follow WB_CNN_ERR_EN when it is defined.
`default_nettype none

module tb_wb_cnn_slave;

`ifdef WB_CNN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat;
  logic        we, cyc, stb;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;
  logic        start_o, done_i;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic        irq;

  int          n_vec = 0;
  int          n_err = 0;
  int          pop_cnt = 0;
  int          start_cnt = 0;
  logic [31:0] pop_data = '0;
  int          base;
  logic [31:0] last_rd;
  logic        last_ack, last_err;

  always #5 clk = ~clk;

  wb_cnn_slave #(.DEPTH(16), .DW(32)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat),
    .wb_sel_i    (4'hF),
    .wb_we_i     (we),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_cti_i    (3'b000),
    .wb_bte_i    (2'b00),
    .wb_dat_o    (dat_o),
    .wb_ack_o    (ack_o),
    .wb_err_o    (err_o),
    .wb_rty_o    (rty_o),
    .cnn_start_o (start_o),
    .cnn_done_i  (done_i),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .out_data_i  (out_data),
    .out_valid_i (out_valid),
    .out_ready_o (out_ready),
    .irq_o       (irq)
  );

  // Pre-edge sampling of the stream handshake and start pulse.
  always @(posedge clk) begin
    if (in_valid && in_ready) begin
      pop_cnt  <= pop_cnt + 1;
      pop_data <= in_data;
    end
    if (start_o) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_start(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    adr = a; we = w; dat = d; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic bus_finish();
    last_rd = '0; last_ack = 1'b0; last_err = 1'b0;
    for (int i = 0; i < 8 && !(last_ack || last_err); i++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        last_rd = dat_o; last_ack = ack_o; last_err = err_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!(last_ack || last_err)) check("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    bus_start(a, 1'b1, d);
    bus_finish();
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_start(a, 1'b0, 32'd0);
    bus_finish();
    check(tag, last_rd, exp);
  endtask

  initial begin
    rst_n = 1'b0; adr = '0; dat = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    done_i = 1'b0; in_ready = 1'b0; out_data = '0; out_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_in_valid", {31'b0, in_valid}, 32'd0);
    check("rst_out_ready", {31'b0, out_ready}, 32'd0);
    check("rst_start_irq", {30'b0, start_o, irq}, 32'd0);
    check("rst_in_data", in_data, 32'd0);
    rst_n = 1'b1;

    // Reset arriving during the ACK cycle aborts the ack and flushes the push
    bus_start(32'h3008, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("mid_ack", {31'b0, ack_o}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ack", {31'b0, ack_o}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("abort_in_valid", {31'b0, in_valid}, 32'd0);
    rst_n = 1'b1;
    rd_check("abort_status", 32'h3004, 32'd0);

    // Single pixel pushed and consumed by a ready core
    in_ready = 1'b1;
    base = pop_cnt;
    wr32(32'h3008, 32'hA5A5_0001);
    check("px_ack", {31'b0, last_ack}, 32'd1);
    repeat (2) @(negedge clk);
    check("px_pop_cnt", 32'(pop_cnt - base), 32'd1);
    check("px_pop_data", pop_data, 32'hA5A5_0001);
    in_ready = 1'b0;
    rd_check("px_status", 32'h3004, 32'd0);
    @(negedge clk);
    check("dat_idle_zero", dat_o, 32'd0);

    // Fill to 16, then overflow
    for (int i = 0; i < 16; i++) wr32(32'h3008, 32'h100 + i);
    check("fill_ack", {31'b0, last_ack}, 32'd1);
    rd_check("full_status", 32'h3004, 32'h1000_0000);
    check("full_head", in_data, 32'h100);
    wr32(32'h3008, 32'h0BAD);
    check("ovf_ack", {31'b0, last_ack}, {31'b0, !ERR_EN});
    check("ovf_err", {31'b0, last_err}, {31'b0, ERR_EN});
    rd_check("ovf_status", 32'h3004, 32'h1000_0004);

    // Bus push blocked by full while the core pops on the same edge
    wr32(32'h3004, 32'h4);
    rd_check("w1c_ovf", 32'h3004, 32'h1000_0000);
    base = pop_cnt;
    bus_start(32'h3008, 1'b1, 32'hCAFE);
    in_ready = 1'b1;
    bus_finish();
    in_ready = 1'b0;
    @(negedge clk);
    check("sim_pop_cnt", 32'(pop_cnt - base), 32'd1);
    check("sim_pop_data", pop_data, 32'h100);
    rd_check("sim_status", 32'h3004, 32'h0F00_0004);
    check("sim_head", in_data, 32'h101);

    // Flush via CTRL.clear, then clear the sticky bit
    wr32(32'h3000, 32'h2);
    check("clr_in_valid", {31'b0, in_valid}, 32'd0);
    rd_check("clr_status", 32'h3004, 32'h0000_0004);
    wr32(32'h3004, 32'h4);
    rd_check("clr_status2", 32'h3004, 32'd0);
    rd_check("in_data_read", 32'h3008, 32'd0);

    // Result FIFO: one core push, one good read, one underflow read
    check("out_ready", {31'b0, out_ready}, 32'd1);
    @(negedge clk);
    out_data = 32'h1234; out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    rd_check("out_lvl", 32'h3004, 32'h0001_0000);
    rd_check("out_read", 32'h300C, 32'h1234);
    bus_start(32'h300C, 1'b0, 32'd0);
    bus_finish();
    check("udf_data", last_rd, 32'd0);
    check("udf_ack", {31'b0, last_ack}, {31'b0, !ERR_EN});
    check("udf_err", {31'b0, last_err}, {31'b0, ERR_EN});
    rd_check("udf_status", 32'h3004, 32'h0000_0008);
    wr32(32'h3004, 32'h8);
    rd_check("udf_w1c", 32'h3004, 32'd0);

    // Start, start-while-busy, done, irq and W1C
    base = start_cnt;
    wr32(32'h3000, 32'h5);
    repeat (2) @(negedge clk);
    check("start_pulse", 32'(start_cnt - base), 32'd1);
    rd_check("ctrl_busy", 32'h3000, 32'h5);
    check("irq_before_done", {31'b0, irq}, 32'd0);
    wr32(32'h3000, 32'h5);
    repeat (2) @(negedge clk);
    check("start_busy_ignored", 32'(start_cnt - base), 32'd1);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    check("irq_set", {31'b0, irq}, 32'd1);
    rd_check("done_status", 32'h3004, 32'h1);
    rd_check("ctrl_idle", 32'h3000, 32'h4);
    wr32(32'h3004, 32'h1);
    check("irq_clear", {31'b0, irq}, 32'd0);

    // Done arriving on the same edge as its W1C keeps done set
    bus_start(32'h3004, 1'b1, 32'h1);
    done_i = 1'b1;
    bus_finish();
    done_i = 1'b0;
    check("done_race_irq", {31'b0, irq}, 32'd1);
    rd_check("done_race_status", 32'h3004, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
